// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the MIPS-lite multicycle control path: state
// encodings, opcode constants and the datapath select encodings that the
// ALU control and datapath muxes also decode.
package mips_lite_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OPC_R    = 6'd0;
  localparam logic [5:0] OPC_LW   = 6'd35;
  localparam logic [5:0] OPC_SW   = 6'd43;
  localparam logic [5:0] OPC_BEQ  = 6'd4;
  localparam logic [5:0] OPC_NORI = 6'd13;
  localparam logic [5:0] OPC_J    = 6'd2;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NOR   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One bundle of every datapath control the FSM produces.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(18'd0);

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath signal bundle. master = control unit,
// slave = datapath / IR side.
interface multicycle_control_if #(
  parameter int OPW = mips_lite_pkg::OPCODE_W
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           pcwrite;
  logic           pcwritecond;
  logic           iord;
  logic           memread;
  logic           memwrite;
  logic           irwrite;
  logic           memtoreg;
  logic           regdest;
  logic           regwrite;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic           zeroext;
  logic [1:0]     aluop;
  logic [1:0]     pcsource;
  logic           illegal;
  logic [3:0]     state;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdest, regwrite, alusrca, alusrcb, zeroext,
           aluop, pcsource, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdest, regwrite, alusrca, alusrcb, zeroext,
           aluop, pcsource, illegal, state
  );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Pure state -> control decode (Moore). The only input besides the state is
// mem_ready, which gates the IR/PC update while fetching.
module control_outdec
  import mips_lite_pkg::*;
(
  input  state_e state_s,
  input  logic   mem_ready_s,
  output ctrl_t  ctrl_s
);

  // Per-state datapath controls; anything not named for a state stays 0.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (state_s)
      S_FETCH: begin
        ctrl_s.memread  = 1'b1;
        ctrl_s.iord     = 1'b0;
        ctrl_s.alusrca  = 1'b0;
        ctrl_s.alusrcb  = SRCB_FOUR;
        ctrl_s.aluop    = ALUOP_ADD;
        ctrl_s.pcsource = PCSRC_ALU;
        ctrl_s.irwrite  = mem_ready_s;
        ctrl_s.pcwrite  = mem_ready_s;
      end
      S_DECODE: begin
        ctrl_s.alusrca = 1'b0;
        ctrl_s.alusrcb = SRCB_IMMSH;
        ctrl_s.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_s.memread = 1'b1;
        ctrl_s.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.regwrite = 1'b1;
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regdest  = 1'b0;
      end
      S_MEMWR: begin
        ctrl_s.memwrite = 1'b1;
        ctrl_s.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_B;
        ctrl_s.aluop   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl_s.regwrite = 1'b1;
        ctrl_s.regdest  = 1'b1;
        ctrl_s.memtoreg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_s.alusrca     = 1'b1;
        ctrl_s.alusrcb     = SRCB_B;
        ctrl_s.aluop       = ALUOP_SUB;
        ctrl_s.pcwritecond = 1'b1;
        ctrl_s.pcsource    = PCSRC_ALUOUT;
      end
      S_IMMEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.zeroext = 1'b1;
        ctrl_s.aluop   = ALUOP_NOR;
      end
      S_IMMWB: begin
        ctrl_s.regwrite = 1'b1;
        ctrl_s.regdest  = 1'b0;
        ctrl_s.memtoreg = 1'b0;
      end
      S_JUMP: begin
        ctrl_s.pcwrite  = 1'b1;
        ctrl_s.pcsource = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        ctrl_s.illegal = 1'b1;
      end
      default: begin
        ctrl_s = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// MIPS-lite multicycle main control: state register, next-state sequencing
// and reset masking of the architectural write enables.
module multicycle_control
  import mips_lite_pkg::*;
#(
  parameter int             OPW           = OPCODE_W,
  parameter logic [OPW-1:0] OP_LW         = OPC_LW,
  parameter logic [OPW-1:0] OP_SW         = OPC_SW,
  parameter logic [OPW-1:0] OP_BEQ        = OPC_BEQ,
  parameter logic [OPW-1:0] OP_NORI       = OPC_NORI,
  parameter logic [OPW-1:0] OP_J          = OPC_J,
  parameter bit             MEM_HANDSHAKE = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [OPW-1:0] OP_R = {OPW{1'b0}};

  state_e state_r;
  state_e state_next_s;
  logic   mem_ready_s;
  ctrl_t  ctrl_dec_s;
  ctrl_t  ctrl_out_s;

  // Without the handshake, memory is assumed to complete every access at once.
  assign mem_ready_s = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // State register with synchronous active-low reset back to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction sequencing; memory states hold until the access completes.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready_s) state_next_s = S_DECODE;
        else             state_next_s = S_FETCH;
      end
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_next_s = S_MEMADR;
        else if (bus.opcode == OP_R)                    state_next_s = S_EXEC;
        else if (bus.opcode == OP_BEQ)                  state_next_s = S_BRANCH;
        else if (bus.opcode == OP_NORI)                 state_next_s = S_IMMEX;
        else if (bus.opcode == OP_J)                    state_next_s = S_JUMP;
        else                                            state_next_s = S_ILLEGAL;
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW) state_next_s = S_MEMRD;
        else                     state_next_s = S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready_s) state_next_s = S_MEMWB;
        else             state_next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready_s) state_next_s = S_FETCH;
        else             state_next_s = S_MEMWR;
      end
      S_EXEC:    state_next_s = S_RTWB;
      S_IMMEX:   state_next_s = S_IMMWB;
      S_MEMWB,
      S_RTWB,
      S_BRANCH,
      S_IMMWB,
      S_JUMP,
      S_ILLEGAL: state_next_s = S_FETCH;
      default:   state_next_s = S_FETCH;
    endcase
  end

  control_outdec u_outdec (
    .state_s     (state_r),
    .mem_ready_s (mem_ready_s),
    .ctrl_s      (ctrl_dec_s)
  );

  // While reset is held, no architectural state may be written.
  always_comb begin
    ctrl_out_s = ctrl_dec_s;
    if (!rst_n) begin
      ctrl_out_s.pcwrite     = 1'b0;
      ctrl_out_s.pcwritecond = 1'b0;
      ctrl_out_s.irwrite     = 1'b0;
      ctrl_out_s.regwrite    = 1'b0;
      ctrl_out_s.memwrite    = 1'b0;
    end else begin
      ctrl_out_s = ctrl_dec_s;
    end
  end

  assign bus.pcwrite     = ctrl_out_s.pcwrite;
  assign bus.pcwritecond = ctrl_out_s.pcwritecond;
  assign bus.iord        = ctrl_out_s.iord;
  assign bus.memread     = ctrl_out_s.memread;
  assign bus.memwrite    = ctrl_out_s.memwrite;
  assign bus.irwrite     = ctrl_out_s.irwrite;
  assign bus.memtoreg    = ctrl_out_s.memtoreg;
  assign bus.regdest     = ctrl_out_s.regdest;
  assign bus.regwrite    = ctrl_out_s.regwrite;
  assign bus.alusrca     = ctrl_out_s.alusrca;
  assign bus.alusrcb     = ctrl_out_s.alusrcb;
  assign bus.zeroext     = ctrl_out_s.zeroext;
  assign bus.aluop       = ctrl_out_s.aluop;
  assign bus.pcsource    = ctrl_out_s.pcsource;
  assign bus.illegal     = ctrl_out_s.illegal;
  assign bus.state       = state_r;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation MIPS-lite main control unit for the multicycle datapath.
- Replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Supports R-format, lw, sw, beq, nori and j, with an optional memory-ready handshake and illegal-opcode detection.
- Sits between the instruction register's opcode field and the datapath mux selects and write enables.

Parameters:
- OPW, 6: opcode width.
- OP_LW, 6'd35: load word opcode.
- OP_SW, 6'd43: store word opcode.
- OP_BEQ, 6'd4: branch-equal opcode.
- OP_NORI, 6'd13: nor-immediate opcode.
- OP_J, 6'd2: jump opcode.
- MEM_HANDSHAKE, 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- opcode  in  OPW  instruction[31:26] from IR
- mem_ready  in  1  memory completed current read/write this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load
- memtoreg  out  1  writeback select: 1=MDR
- regdest  out  1  destination select: 1=rd, 0=rt
- regwrite  out  1  register file write
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
- zeroext  out  1  immediate extender: 1=zero-extend (nori), 0=sign-extend
- aluop  out  2  00=add, 01=sub, 10=funct, 11=nor
- pcsource  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug

Behaviour:
- Reset: when rst_n==0 at a clk edge, state<=FETCH.
  - While rst_n==0, pcwrite, pcwritecond, irwrite, regwrite and memwrite are forced 0 combinationally.
  - After release, outputs take FETCH values.
- Output timing: all outputs decode from state only (Moore), except irwrite/pcwrite in FETCH, which equal mem_ready.
- Default outputs: every output not listed for a state is 0.
- FETCH(0): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00, irwrite=pcwrite=mem_ready.
  - Go to DECODE when mem_ready, else hold.
- DECODE(1): alusrca=0, alusrcb=11, aluop=00 (branch target).
  - lw/sw -> MEMADR; R (opcode==0) -> EXEC; beq -> BRANCH; nori -> IMMEX; j -> JUMP; any other -> ILLEGAL.
- MEMADR(2): alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR (opcode is stable, held by IR).
- MEMRD(3): memread=1, iord=1. Go to MEMWB on mem_ready, else hold.
- MEMWB(4): regwrite=1, memtoreg=1, regdest=0. -> FETCH.
- MEMWR(5): memwrite=1, iord=1. Go to FETCH on mem_ready, else hold with memwrite still 1.
- EXEC(6): alusrca=1, alusrcb=00, aluop=10. -> RTWB.
- RTWB(7): regwrite=1, regdest=1, memtoreg=0. -> FETCH.
- BRANCH(8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. -> FETCH.
- IMMEX(9): alusrca=1, alusrcb=10, zeroext=1, aluop=11. -> IMMWB.
- IMMWB(10): regwrite=1, regdest=0, memtoreg=0. -> FETCH.
- JUMP(11): pcwrite=1, pcsource=10. -> FETCH.
- ILLEGAL(12): illegal=1, no write enables asserted. -> FETCH (instruction is skipped; PC was already incremented).
- Unused encodings 13-15 -> FETCH next cycle, all outputs 0.
- Latency with mem_ready tied 1: beq/j/illegal 3 cycles; R/sw/nori 4; lw 5.
  - Each low-mem_ready cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset mid-instruction: abandons the instruction; no write enable is asserted in the reset cycle; resumes at FETCH.
- MEM_HANDSHAKE=0: behaves as if mem_ready==1 always.

Decomposition:
- Package mips_lite_pkg holds:
  - state encodings (FETCH..ILLEGAL, 4-bit);
  - opcode constants;
  - aluop, alusrcb and pcsource encodings, shared with alu_control and the datapath muxes.
- One sub-module, control_outdec: purely combinational state -> output decode.
- The top holds the state register and next-state logic.

Test Plan:
1. mem_ready=1, opcode=0 -> states 0,1,6,7,0; regwrite=1 and regdest=1 only in state 7; aluop=10 in state 6.
2. opcode=35, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; memread=1 and iord=1 throughout state 3; memtoreg=1 and regwrite=1 in state 4.
3. opcode=43, mem_ready=1 -> states 0,1,2,5,0; memwrite=1 exactly one cycle; regwrite never 1.
4. opcode=13 -> states 0,1,9,10,0; zeroext=1 and aluop=11 in state 9; regwrite=1 with regdest=0 in state 10.
5. opcode=4, then opcode=2 -> beq: pcwritecond=1 and pcsource=01 in state 8. j: pcwrite=1 and pcsource=10 in state 11. Both return to 0 after 3 cycles.
6. opcode=63 -> illegal pulses 1 cycle in state 12, then FETCH. Separately, rst_n=0 asserted during MEMWR -> memwrite=0 that cycle, state=0 next edge.
